// File: rtl/sdram_resp_pkg.sv
// Shared constants and helpers for the SDRAM sample responder.
// Covers the bad-address fill word, the stall-inject LFSR and the error counter width.
package sdram_resp_pkg;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEADBEEF;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam int unsigned ERR_W         = 16;
  localparam logic [ERR_W-1:0] ERR_MAX  = 16'hFFFF;

  // Galois form: shift right, fold taps back in when the bit leaving is 1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/read_return_pipe.sv
// Fixed-latency valid+data shift register that carries read returns to the bus.
// Reset flushes every stage, so reads in flight at reset never return.
module read_return_pipe #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [LATENCY-1:0] r_valid;
  logic [DATA_W-1:0]  r_data [LATENCY];

  // stage 0 captures the RAM word at acceptance; later stages just shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/sdram_sample_responder.sv
// Avalon-MM pipelined-read slave over an on-chip sample RAM with fixed read latency.
// Optional random stall injection is enabled with `define SDRAM_RESPONDER_STALL_INJECT_EN.
module sdram_sample_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned MAX_PENDING  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic              waitrequest,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PEND_W  = $clog2(MAX_PENDING + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [31:0]       r_ram [DEPTH];
  logic [PEND_W-1:0] r_pending;
  logic [31:0]       r_rd_count;
  logic [31:0]       r_wr_count;
  logic [ERR_W-1:0]  r_err_count;

  logic [ADDR_W-3:0] w_word;
  logic [IDX_W-1:0]  w_ram_idx;
  logic              w_in_range;
  logic [31:0]       w_rd_data;
  logic              w_retire;
  logic              w_inject;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_err_evt;
  logic              w_unused;

  assign w_word     = address[ADDR_W-1:2];
  assign w_ram_idx  = w_word[IDX_W-1:0];
  assign w_in_range = (32'(w_word) < DEPTH_W);
  assign w_unused   = &{1'b0, address[1:0]};

`ifdef SDRAM_RESPONDER_STALL_INJECT_EN
  logic [15:0] r_lfsr;

  // free-running stall pattern, independent of the command stream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_inject = (r_lfsr[2:0] == 3'b000);
`else
  assign w_inject = 1'b0;
`endif

  // a read at the pending limit still goes through in the cycle a return retires
  assign waitrequest = !reset_n | (read & write)
                     | (read & (r_pending == PEND_W'(MAX_PENDING)) & !w_retire)
                     | w_inject;

  assign w_rd_acc  = read  & !waitrequest;
  assign w_wr_acc  = write & !waitrequest;
  assign w_err_evt = ((w_rd_acc | w_wr_acc) & !w_in_range) | (reset_n & read & write);
  assign w_rd_data = w_in_range ? r_ram[w_ram_idx] : BAD_ADDR_DATA;

  // sample store: contents survive reset, out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      r_ram[w_ram_idx] <= writedata;
    end
  end

  // in-flight tracking and access/error statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending   <= '0;
      r_rd_count  <= 32'd0;
      r_wr_count  <= 32'd0;
      r_err_count <= '0;
    end else begin
      case ({w_rd_acc, w_retire})
        2'b10:   r_pending <= r_pending + PEND_W'(1);
        2'b01:   r_pending <= r_pending - PEND_W'(1);
        default: r_pending <= r_pending;
      endcase
      if (w_rd_acc) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_wr_acc) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
      if (w_err_evt && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  read_return_pipe #(
    .LATENCY (READ_LATENCY),
    .DATA_W  (32)
  ) u_return_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_rd_acc),
    .i_data  (w_rd_data),
    .o_valid (w_retire),
    .o_data  (readdata)
  );

  assign readdatavalid = w_retire;
  assign rd_count      = r_rd_count;
  assign wr_count      = r_wr_count;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_sdram_sample_responder.sv
// Directed self-checking bench for sdram_sample_responder (default and MAX_PENDING=1 instances).
module tb_sdram_sample_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] address;
  logic        read, write;
  logic [31:0] writedata;
  logic        waitrequest, readdatavalid;
  logic [31:0] readdata, rd_count, wr_count;
  logic [15:0] err_count;

  logic [23:0] address1;
  logic        read1, write1;
  logic [31:0] writedata1;
  logic        waitrequest1, readdatavalid1;
  logic [31:0] readdata1, rd_count1, wr_count1;
  logic [15:0] err_count1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] ret_q[$];
  int          ret_cyc_q[$];

  sdram_sample_responder #(.ADDR_W(24), .DEPTH(1024), .READ_LATENCY(3), .MAX_PENDING(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .rd_count(rd_count), .wr_count(wr_count),
    .err_count(err_count)
  );

  sdram_sample_responder #(.ADDR_W(24), .DEPTH(1024), .READ_LATENCY(3), .MAX_PENDING(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address1), .read(read1), .write(write1),
    .writedata(writedata1), .waitrequest(waitrequest1), .readdata(readdata1),
    .readdatavalid(readdatavalid1), .rd_count(rd_count1), .wr_count(wr_count1),
    .err_count(err_count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc at the negedge equals the index of the posedge that just passed
  always @(negedge clk) begin
    if (readdatavalid) begin
      ret_q.push_back(readdata);
      ret_cyc_q.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a negedge with a command driven; returns the index of the accepting edge
  task automatic wait_accept(output int acc);
    int n = 0;
    #1;
    while (waitrequest && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) check_val("accept_timeout", 32'd1, 32'd0);
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [31:0] d);
    int acc;
    address = a; writedata = d; write = 1'b1;
    wait_accept(acc);
    write = 1'b0;
  endtask

  task automatic do_read(input logic [23:0] a, output int acc);
    address = a; read = 1'b1;
    wait_accept(acc);
    read = 1'b0;
  endtask

  task automatic get_return(output logic [31:0] d, output int c);
    int n = 0;
    #2;
    while (ret_q.size() == 0 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (ret_q.size() == 0) begin
      check_val("return_timeout", 32'd1, 32'd0);
      d = 32'h0;
      c = 0;
    end else begin
      d = ret_q.pop_front();
      c = ret_cyc_q.pop_front();
    end
  endtask

  initial begin
    logic [31:0] d;
    int acc, c, c_first, c_last, stalls, n_acc, guard;

    reset_n = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    address1 = '0; read1 = 1'b0; write1 = 1'b0; writedata1 = '0;
    repeat (3) @(negedge clk);

    read = 1'b1;
    #1;
    check_val("rst_waitreq", 32'(waitrequest), 32'd1);
    check_val("rst_rdv", 32'(readdatavalid), 32'd0);
    check_val("rst_rdcnt", rd_count, 32'd0);
    check_val("rst_errcnt", 32'(err_count), 32'd0);
    read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // MAX_PENDING=1, latency 3: a held read is accepted once every 3 cycles
    read1 = 1'b1;
    stalls = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (waitrequest1) stalls++;
      @(negedge clk);
    end
    read1 = 1'b0;
`ifndef SDRAM_RESPONDER_STALL_INJECT_EN
    check_val("mp1_stalls", 32'(stalls), 32'd6);
    check_val("mp1_rdcnt", rd_count1, 32'd3);
`endif
    repeat (4) @(negedge clk);

    // write then read back; return seen after edge acc+2
    do_write(24'h000010, 32'h11223344);
    do_read(24'h000010, acc);
    get_return(d, c);
    check_val("t1_data", d, 32'h11223344);
    check_val("t1_latency", 32'(c - acc), 32'd2);

    for (int i = 0; i < 8; i++) do_write(24'(i * 4), 32'hA0000000 + 32'(i));

    address = 24'h000000; read = 1'b1;
    n_acc = 0; guard = 0; stalls = 0;
    while (n_acc < 8 && guard < 100) begin
      #1;
      if (waitrequest) begin
        stalls++;
        @(negedge clk);
      end else begin
        @(negedge clk);
        n_acc++;
        address = address + 24'd4;
      end
      guard++;
    end
    read = 1'b0;
`ifndef SDRAM_RESPONDER_STALL_INJECT_EN
    check_val("t2_stalls", 32'(stalls), 32'd0);
`endif
    c_first = 0; c_last = 0;
    for (int i = 0; i < 8; i++) begin
      get_return(d, c);
      check_val($sformatf("t2_data%0d", i), d, 32'hA0000000 + 32'(i));
      if (i == 0) c_first = c;
      c_last = c;
    end
`ifndef SDRAM_RESPONDER_STALL_INJECT_EN
    check_val("t2_rate", 32'(c_last - c_first), 32'd7);
`endif
    check_val("t2_rdcnt", rd_count, 32'd9);

    // word 1024 is out of range and aliases word 0 in its low index bits
    do_read(24'h001000, acc);
    get_return(d, c);
    check_val("t4_bad_data", d, 32'hDEADBEEF);
    check_val("t4_err1", 32'(err_count), 32'd1);
    do_write(24'h001000, 32'h55555555);
    check_val("t4_err2", 32'(err_count), 32'd2);
    do_read(24'h000000, acc);
    get_return(d, c);
    check_val("t4_word0", d, 32'hA0000000);

    address = 24'h000004; writedata = 32'hBAD0BAD0; read = 1'b1; write = 1'b1;
    #1;
    check_val("t5_waitreq_a", 32'(waitrequest), 32'd1);
    @(negedge clk);
    #1;
    check_val("t5_waitreq_b", 32'(waitrequest), 32'd1);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    #1;
    check_val("t5_err", 32'(err_count), 32'd4);
    do_read(24'h000004, acc);
    get_return(d, c);
    check_val("t5_ram_kept", d, 32'hA0000001);
    check_val("t5_rdcnt", rd_count, 32'd12);
    check_val("t5_wrcnt", wr_count, 32'd10);

    // two reads in flight, then reset before either returns
    repeat (4) @(negedge clk);
    #2;
    check_val("t6_q_empty", 32'(ret_q.size()), 32'd0);
    address = 24'h000000; read = 1'b1;
    wait_accept(acc);
    address = 24'h000004;
    wait_accept(acc);
    read = 1'b0;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check_val("t6_no_rdv", 32'(ret_q.size()), 32'd0);
    check_val("t6_rdcnt", rd_count, 32'd0);
    check_val("t6_wrcnt", wr_count, 32'd0);
    check_val("t6_errcnt", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    do_read(24'h000010, acc);
    get_return(d, c);
    check_val("t6_ram_kept", d, 32'hA0000004);
    check_val("t6_rdcnt_after", rd_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
